// File: rtl/sc2110_sync_pkg.sv
// Shared constants and types for the SC2110 embedded-sync encoder.
// Sync words are FFF 000 000 XYZ; the XYZ code identifies SOF/SAV/EAV/EOF.
package sc2110_sync_pkg;

    localparam logic [11:0] SYNC_W0  = 12'hFFF;
    localparam logic [11:0] SYNC_W12 = 12'h000;
    localparam logic [11:0] CODE_SOF = 12'hAB0;
    localparam logic [11:0] CODE_EOF = 12'hB60;
    localparam logic [11:0] CODE_SAV = 12'h800;
    localparam logic [11:0] CODE_EAV = 12'h9D0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_ACTIVE,
        ST_EOF,
        ST_VBLANK
    } enc_state_t;

    typedef enum logic [2:0] {
        SLOT_BLANK,
        SLOT_PIX,
        SLOT_SOF,
        SLOT_SAV,
        SLOT_EAV,
        SLOT_EOF
    } slot_t;

    // Word at position idx (0..3) of a four-word sync sequence of the given kind.
    function automatic logic [11:0] code_word(input slot_t s, input logic [1:0] idx);
        logic [11:0] w;
        case (idx)
            2'd0:    w = SYNC_W0;
            2'd1,
            2'd2:    w = SYNC_W12;
            default: begin
                case (s)
                    SLOT_SOF: w = CODE_SOF;
                    SLOT_SAV: w = CODE_SAV;
                    SLOT_EAV: w = CODE_EAV;
                    SLOT_EOF: w = CODE_EOF;
                    default:  w = SYNC_W12;
                endcase
            end
        endcase
        return w;
    endfunction

endpackage

// File: rtl/sc2110_sync_timing.sv
// Line/frame timing for the SC2110 sync encoder: h/v counters, frame FSM
// and per-slot decode (slot kind, index inside a sync sequence, pixel request).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | stream stopped, counters held at 0, waiting for I_enable
// ST_SOF    | one line carrying the SOF code, rest blank
// ST_ACTIVE | V_ACTIVE lines: SAV, H_ACTIVE pixels, EAV, blank filler
// ST_EOF    | one line carrying the EOF code, rest blank
// ST_VBLANK | V_BLANK all-blank lines; frame boundary on the last slot
module sc2110_sync_timing
    import sc2110_sync_pkg::*;
#(
    parameter int H_ACTIVE = 1920,
    parameter int H_BLANK  = 280,
    parameter int V_ACTIVE = 1080,
    parameter int V_BLANK  = 40
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       I_enable,
    output enc_state_t state,
    output slot_t      slot,
    output logic [1:0] code_idx,
    output logic       pix_req,
    output logic       frame_done
);

    localparam int H_TOTAL = 4 + H_ACTIVE + 4 + H_BLANK;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int V_MAX   = (V_ACTIVE > V_BLANK) ? V_ACTIVE : V_BLANK;
    localparam int VW      = $clog2(V_MAX + 1);

    enc_state_t      state_nxt;
    logic [HW-1:0]   h_cnt;
    logic [VW-1:0]   v_cnt;
    logic            line_end;
    logic            last_active;
    logic            last_blank;

    assign line_end    = (h_cnt == HW'(H_TOTAL - 1));
    assign last_active = (v_cnt == VW'(V_ACTIVE - 1));
    assign last_blank  = (v_cnt == VW'(V_BLANK - 1));
    assign frame_done  = (state == ST_VBLANK) && line_end && last_blank;

    // State register.
    always_ff @(posedge I_clk) begin
        if (I_rst) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next-state: IDLE leaves immediately (h_cnt is held at 0), all others at line wrap.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (I_enable) state_nxt = ST_SOF;
            ST_SOF:    if (line_end) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (line_end && last_active) state_nxt = ST_EOF;
            ST_EOF:    if (line_end) state_nxt = ST_VBLANK;
            ST_VBLANK: if (line_end && last_blank) state_nxt = I_enable ? ST_SOF : ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Slot counter per line and line counter per state; v_cnt restarts on every state change.
    always_ff @(posedge I_clk) begin
        if (I_rst || state == ST_IDLE) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + HW'(1);
            if (line_end) v_cnt <= (state_nxt != state) ? '0 : v_cnt + VW'(1);
        end
    end

    // Slot decode from state and h_cnt.
    always_comb begin
        slot     = SLOT_BLANK;
        code_idx = h_cnt[1:0];
        pix_req  = 1'b0;
        case (state)
            ST_SOF: if (h_cnt < HW'(4)) slot = SLOT_SOF;
            ST_ACTIVE: begin
                if (h_cnt < HW'(4)) begin
                    slot = SLOT_SAV;
                end else if (h_cnt < HW'(4 + H_ACTIVE)) begin
                    slot    = SLOT_PIX;
                    pix_req = 1'b1;
                end else if (h_cnt < HW'(8 + H_ACTIVE)) begin
                    slot = SLOT_EAV;
                    // EAV starts at 4+H_ACTIVE; only the low two bits of the offset matter.
                    code_idx = h_cnt[1:0] - 2'(H_ACTIVE % 4);
                end
            end
            ST_EOF: if (h_cnt < HW'(4)) slot = SLOT_EOF;
            default: ;
        endcase
    end

endmodule

// File: rtl/sc2110_sync_encoder.sv
// SC2110 embedded-sync encoder: emits a 12-bit stream with FFF 000 000 XYZ
// codes around upstream pixels. Optional macro SC2110_SYNC_ENC_DATA_CLIP_EN
// remaps pixel FFF->FFE and 000->001 so payload can never mimic a sync prefix.
module sc2110_sync_encoder
    import sc2110_sync_pkg::*;
#(
    parameter int          H_ACTIVE   = 1920,
    parameter int          H_BLANK    = 280,
    parameter int          V_ACTIVE   = 1080,
    parameter int          V_BLANK    = 40,
    parameter logic [11:0] BLANK_WORD = 12'h040
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_enable,
    input  logic [11:0] I_pix_data,
    output logic        O_pix_req,
    output logic [11:0] O_data,
    output logic        O_data_valid,
    output logic [15:0] O_frame_cnt,
    output logic        O_busy
);

    enc_state_t  state;
    slot_t       slot;
    logic [1:0]  code_idx;
    logic        frame_done;
    logic [11:0] pix_word;
    logic [11:0] word_nxt;

    sc2110_sync_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_BLANK  (H_BLANK),
        .V_ACTIVE (V_ACTIVE),
        .V_BLANK  (V_BLANK)
    ) u_timing (
        .I_clk      (I_clk),
        .I_rst      (I_rst),
        .I_enable   (I_enable),
        .state      (state),
        .slot       (slot),
        .code_idx   (code_idx),
        .pix_req    (O_pix_req),
        .frame_done (frame_done)
    );

    assign O_busy = (state != ST_IDLE);

    // Pixel payload, optionally clipped away from the sync prefix values.
    always_comb begin
`ifdef SC2110_SYNC_ENC_DATA_CLIP_EN
        if (I_pix_data == 12'hFFF)      pix_word = 12'hFFE;
        else if (I_pix_data == 12'h000) pix_word = 12'h001;
        else                            pix_word = I_pix_data;
`else
        pix_word = I_pix_data;
`endif
    end

    // Word mux: idle emits 000, otherwise pixel, filler or sync code.
    always_comb begin
        word_nxt = 12'h000;
        if (state != ST_IDLE) begin
            case (slot)
                SLOT_PIX:   word_nxt = pix_word;
                SLOT_BLANK: word_nxt = BLANK_WORD;
                default:    word_nxt = code_word(slot, code_idx);
            endcase
        end
    end

    // Output register and completed-frame counter.
    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            O_data       <= 12'h000;
            O_data_valid <= 1'b0;
            O_frame_cnt  <= 16'h0000;
        end else begin
            O_data       <= word_nxt;
            O_data_valid <= (state != ST_IDLE);
            if (frame_done) O_frame_cnt <= O_frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_sc2110_sync_encoder.sv
// Bench for sc2110_sync_encoder with a 20-slot, 7-line frame (140 words).
// A per-slot expected-frame table drives and checks every word; a small
// sync decoder watches the stream for line/pixel/frame structure.
module tb_sc2110_sync_encoder;

    localparam int NFR = 140;

    typedef struct {
        logic [11:0] pix;
        logic [11:0] data;
        logic        req;
    } vec_t;

    logic        I_clk = 1'b0;
    logic        I_rst = 1'b1;
    logic        I_enable = 1'b0;
    logic [11:0] I_pix_data = 12'h000;
    logic        O_pix_req;
    logic [11:0] O_data;
    logic        O_data_valid;
    logic [15:0] O_frame_cnt;
    logic        O_busy;

    int checks = 0;
    int errors = 0;

    vec_t        tbl [NFR];
    logic [11:0] prev_d;
    logic        prev_v;

    logic [11:0] h0 = 12'h123, h1 = 12'h123, h2 = 12'h123;
    bit          in_line = 0;
    int          pcnt = 0, lines = 0, dec_frames = 0, dec_sofs = 0;

    sc2110_sync_encoder #(
        .H_ACTIVE (8),
        .H_BLANK  (4),
        .V_ACTIVE (3),
        .V_BLANK  (2),
        .BLANK_WORD (12'h040)
    ) dut (
        .I_clk        (I_clk),
        .I_rst        (I_rst),
        .I_enable     (I_enable),
        .I_pix_data   (I_pix_data),
        .O_pix_req    (O_pix_req),
        .O_data       (O_data),
        .O_data_valid (O_data_valid),
        .O_frame_cnt  (O_frame_cnt),
        .O_busy       (O_busy)
    );

    always #5 I_clk = ~I_clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference sync decoder on the output stream.
    task automatic decode();
        if (O_data_valid) begin
            if (h0 == 12'hFFF && h1 == 12'h000 && h2 == 12'h000 &&
                (O_data == 12'hAB0 || O_data == 12'h800 || O_data == 12'h9D0 || O_data == 12'hB60)) begin
                case (O_data)
                    12'hAB0: begin dec_sofs++; lines = 0; in_line = 0; end
                    12'h800: begin in_line = 1; pcnt = 0; end
                    12'h9D0: begin
                        chk("dec_pix_per_line", pcnt - 3, 8);
                        in_line = 0;
                        lines++;
                    end
                    default: begin
                        chk("dec_lines_per_frame", lines, 3);
                        dec_frames++;
                    end
                endcase
            end else if (in_line) begin
                pcnt++;
            end
            h0 = h1; h1 = h2; h2 = O_data;
        end
    endtask

    task automatic step(input logic [11:0] ed, input logic ev, input logic er, input logic [11:0] pix);
        chk("O_data", int'(O_data), int'(ed));
        chk("O_data_valid", int'(O_data_valid), int'(ev));
        chk("O_pix_req", int'(O_pix_req), int'(er));
        decode();
        I_pix_data = pix;
        @(posedge I_clk);
        #1;
    endtask

    task automatic run_frame(input int n, input int drop, input bit clip);
        logic [11:0] d, p;
        for (int k = 0; k < n; k++) begin
            if (k == drop) I_enable = 1'b0;
            d = tbl[k].data;
            p = tbl[k].pix;
            if (clip && k == 24) begin
                p = 12'hFFF;
`ifdef SC2110_SYNC_ENC_DATA_CLIP_EN
                d = 12'hFFE;
`else
                d = 12'hFFF;
`endif
            end
            if (clip && k == 25) begin
                p = 12'h000;
`ifdef SC2110_SYNC_ENC_DATA_CLIP_EN
                d = 12'h001;
`else
                d = 12'h000;
`endif
            end
            step(prev_d, prev_v, tbl[k].req, p);
            prev_d = d;
            prev_v = 1'b1;
        end
    endtask

    initial begin
        // Expected frame: line 0 SOF, lines 1-3 active, line 4 EOF, lines 5-6 blank.
        for (int k = 0; k < NFR; k++) begin
            int ln, s;
            logic [11:0] code;
            ln = k / 20;
            s  = k % 20;
            tbl[k].pix  = 12'h5A5;
            tbl[k].data = 12'h040;
            tbl[k].req  = 1'b0;
            code = 12'h040;
            if (ln == 0) code = 12'hAB0;
            else if (ln <= 3) code = 12'h800;
            else if (ln == 4) code = 12'hB60;
            if (ln <= 4 && s < 4)
                tbl[k].data = (s == 0) ? 12'hFFF : (s == 3) ? code : 12'h000;
            if (ln >= 1 && ln <= 3) begin
                if (s >= 4 && s < 12) begin
                    tbl[k].pix  = 12'h100 + 12'(s - 4);
                    tbl[k].data = tbl[k].pix;
                    tbl[k].req  = 1'b1;
                end else if (s >= 12 && s < 16) begin
                    tbl[k].data = (s == 12) ? 12'hFFF : (s == 15) ? 12'h9D0 : 12'h000;
                end
            end
        end

        // Reset values.
        repeat (3) @(posedge I_clk);
        #1;
        chk("rst O_data", int'(O_data), 0);
        chk("rst O_data_valid", int'(O_data_valid), 0);
        chk("rst O_pix_req", int'(O_pix_req), 0);
        chk("rst O_frame_cnt", int'(O_frame_cnt), 0);
        chk("rst O_busy", int'(O_busy), 0);

        // Start: three continuous frames.
        I_rst = 1'b0;
        I_enable = 1'b1;
        step(12'h000, 1'b0, 1'b0, 12'h000);
        chk("busy after start", int'(O_busy), 1);
        prev_d = 12'h000;
        prev_v = 1'b0;
        for (int f = 0; f < 3; f++) begin
            run_frame(NFR, -1, 1'b0);
            chk("frame_cnt continuous", int'(O_frame_cnt), f + 1);
        end

        // Enable dropped mid-ACTIVE: frame completes, then idle.
        run_frame(NFR, 30, 1'b0);
        chk("busy after drop", int'(O_busy), 0);
        chk("frame_cnt after drop", int'(O_frame_cnt), 4);
        step(prev_d, prev_v, 1'b0, 12'h000);
        step(12'h000, 1'b0, 1'b0, 12'h000);
        chk("busy idle", int'(O_busy), 0);

        // Restart and reset during the EOF line.
        I_enable = 1'b1;
        step(12'h000, 1'b0, 1'b0, 12'h000);
        prev_d = 12'h000;
        prev_v = 1'b0;
        run_frame(86, -1, 1'b0);
        I_rst = 1'b1;
        step(prev_d, prev_v, 1'b0, 12'h000);
        chk("midrst O_data", int'(O_data), 0);
        chk("midrst O_data_valid", int'(O_data_valid), 0);
        chk("midrst O_frame_cnt", int'(O_frame_cnt), 0);
        chk("midrst O_busy", int'(O_busy), 0);
        chk("midrst O_pix_req", int'(O_pix_req), 0);
        I_rst = 1'b0;
        step(12'h000, 1'b0, 1'b0, 12'h000);
        prev_d = 12'h000;
        prev_v = 1'b0;
        run_frame(NFR, -1, 1'b0);
        chk("frame_cnt after reset", int'(O_frame_cnt), 1);

        // Pixels FFF/000 on the first active line.
        run_frame(NFR, -1, 1'b1);
        chk("frame_cnt after clip frame", int'(O_frame_cnt), 2);

        chk("dec frames", dec_frames, 7);
        chk("dec sofs", dec_sofs, 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
